// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared constants for the pipeline hold/flush scheduler: FSM state encodings
// and the flush polarity (a flushed pipeline register loads a NOP).
package pipe_hold_ctrl_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_BUBBLE     = 3'd1;
  localparam logic [2:0] ST_REDIR_WAIT = 3'd2;
  localparam logic [2:0] ST_DRAIN      = 3'd3;
  localparam logic [2:0] ST_INT_ENTRY  = 3'd4;

  // Level that makes a pipeline register load a NOP instead of its input
  localparam logic FLUSH_NOP = 1'b1;

  localparam int unsigned           DRAIN_W      = 2;
  localparam logic [DRAIN_W-1:0]    DRAIN_RELOAD = 2'd2;

endpackage

// File: rtl/pipe_bubble_cnt.sv
// Loadable saturating down-counter with zero flag; load has priority over decrement.
module pipe_bubble_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Stall/flush scheduler for the 3-stage pipeline and owner of the PC redirect port.
// Interrupt drain/entry handling is built only when PIPE_CTRL_INT_EN is defined.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_req_i,
  input  logic [PC_W-1:0] jump_addr_i,
  input  logic            hold_ex_i,
  input  logic            hold_bus_i,
  input  logic            int_req_i,
  input  logic [PC_W-1:0] int_addr_i,
  output logic            int_ack_o,
  output logic            pc_stall_o,
  output logic            if_id_stall_o,
  output logic            id_ex_stall_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            redirect_o,
  output logic [PC_W-1:0] redirect_addr_o
);

  localparam int unsigned    BW         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic           HAS_BUBBLE = (FLUSH_CYC > 1);
  localparam logic [BW-1:0]  BUB_RELOAD = BW'(FLUSH_CYC - 1);

  logic [ST_W-1:0] r_state;
  logic [PC_W-1:0] r_addr;
  logic [ST_W-1:0] w_state_nxt;
  logic [PC_W-1:0] w_addr_nxt;

  logic            w_bub_load;
  logic            w_bub_dec;
  logic [BW-1:0]   w_bub_cnt;
  logic            w_bub_zero;
  logic            w_bub_last;

  logic            w_arb;
  logic            w_drain_drop;
  logic            w_ack;
  logic            w_redir;
  logic [PC_W-1:0] w_redir_addr;
  logic            w_pc_st;
  logic            w_if_st;
  logic            w_ie_st;
  logic            w_if_fl;
  logic            w_ie_fl;

  pipe_bubble_cnt #(.W(BW)) u_bub_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_bub_load),
    .i_load_val (BUB_RELOAD),
    .i_dec      (w_bub_dec),
    .o_cnt      (w_bub_cnt),
    .o_zero     (w_bub_zero)
  );

  // Last bubble cycle; the zero term keeps the FSM from sticking on a stale count
  assign w_bub_last = (w_bub_cnt == BW'(1)) || w_bub_zero;

`ifdef PIPE_CTRL_INT_EN
  logic               w_drn_load;
  logic               w_drn_dec;
  logic [DRAIN_W-1:0] w_drn_cnt;
  logic               w_drn_zero;
  logic               w_drn_last;

  pipe_bubble_cnt #(.W(DRAIN_W)) u_drn_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_drn_load),
    .i_load_val (DRAIN_RELOAD),
    .i_dec      (w_drn_dec),
    .o_cnt      (w_drn_cnt),
    .o_zero     (w_drn_zero)
  );

  assign w_drn_last   = (w_drn_cnt == DRAIN_W'(1)) || w_drn_zero;
  assign w_drain_drop = (r_state == ST_DRAIN) && !int_req_i;
`else
  logic w_unused_int;
  assign w_unused_int = ^{int_req_i, int_addr_i};
  assign w_drain_drop = 1'b0;
`endif

  // Cycles that run the IDLE request arbitration (a dropped interrupt falls back to it)
  assign w_arb = (r_state == ST_IDLE) || ((r_state == ST_BUBBLE) && jump_req_i) || w_drain_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_bub_load   = 1'b0;
    w_bub_dec    = 1'b0;
`ifdef PIPE_CTRL_INT_EN
    w_drn_load   = 1'b0;
    w_drn_dec    = 1'b0;
`endif
    w_ack        = 1'b0;
    w_redir      = 1'b0;
    w_redir_addr = '0;
    w_pc_st      = 1'b0;
    w_if_st      = 1'b0;
    w_ie_st      = 1'b0;
    w_if_fl      = 1'b0;
    w_ie_fl      = 1'b0;

    if (w_arb) begin
      if (jump_req_i) begin
        w_redir      = 1'b1;
        w_redir_addr = jump_addr_i;
        w_if_fl      = FLUSH_NOP;
        w_ie_fl      = FLUSH_NOP;
        if (hold_bus_i) begin
          w_addr_nxt  = jump_addr_i;
          w_state_nxt = ST_REDIR_WAIT;
        end else begin
          w_bub_load  = HAS_BUBBLE;
          w_state_nxt = HAS_BUBBLE ? ST_BUBBLE : ST_IDLE;
        end
      end
`ifdef PIPE_CTRL_INT_EN
      else if (int_req_i) begin
        w_pc_st     = 1'b1;
        w_if_fl     = FLUSH_NOP;
        w_ie_st     = hold_ex_i;
        w_drn_load  = 1'b1;
        w_state_nxt = ST_DRAIN;
      end
`endif
      else if (hold_ex_i) begin
        w_pc_st     = 1'b1;
        w_if_st     = 1'b1;
        w_ie_st     = 1'b1;
        w_state_nxt = ST_IDLE;
      end else if (hold_bus_i) begin
        w_pc_st     = 1'b1;
        w_if_fl     = FLUSH_NOP;
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_BUBBLE: begin
          w_if_fl   = FLUSH_NOP;
          w_pc_st   = hold_ex_i || hold_bus_i;
          w_ie_st   = hold_ex_i;
          w_bub_dec = 1'b1;
          if (w_bub_last) w_state_nxt = ST_IDLE;
        end
        // Keep presenting the latched target until the fetch bus takes it
        ST_REDIR_WAIT: begin
          w_redir      = 1'b1;
          w_redir_addr = r_addr;
          w_if_fl      = FLUSH_NOP;
          w_ie_st      = hold_ex_i;
          if (!hold_bus_i) begin
            w_bub_load  = HAS_BUBBLE;
            w_state_nxt = HAS_BUBBLE ? ST_BUBBLE : ST_IDLE;
          end
        end
`ifdef PIPE_CTRL_INT_EN
        ST_DRAIN: begin
          w_pc_st = 1'b1;
          w_if_fl = FLUSH_NOP;
          w_ie_st = hold_ex_i;
          if (jump_req_i) begin
            w_redir      = 1'b1;
            w_redir_addr = jump_addr_i;
            w_ie_fl      = FLUSH_NOP;
            w_pc_st      = 1'b0;
            w_drn_load   = 1'b1;
          end else if (!hold_ex_i) begin
            w_drn_dec = 1'b1;
            if (w_drn_last) w_state_nxt = ST_INT_ENTRY;
          end
        end
        ST_INT_ENTRY: begin
          w_ack        = 1'b1;
          w_redir      = 1'b1;
          w_redir_addr = int_addr_i;
          w_if_fl      = FLUSH_NOP;
          w_ie_fl      = FLUSH_NOP;
          if (hold_bus_i) begin
            w_addr_nxt  = int_addr_i;
            w_state_nxt = ST_REDIR_WAIT;
          end else begin
            w_bub_load  = HAS_BUBBLE;
            w_state_nxt = HAS_BUBBLE ? ST_BUBBLE : ST_IDLE;
          end
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Flush beats stall on the same register, redirect beats PC stall; all quiet in reset
  assign int_ack_o       = rst & w_ack;
  assign redirect_o      = rst & w_redir;
  assign redirect_addr_o = rst ? w_redir_addr : '0;
  assign pc_stall_o      = rst & w_pc_st & ~w_redir;
  assign if_id_stall_o   = rst & w_if_st & ~w_if_fl;
  assign id_ex_stall_o   = rst & w_ie_st & ~w_ie_fl;
  assign if_id_flush_o   = rst & w_if_fl;
  assign id_ex_flush_o   = rst & w_ie_fl;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl (FLUSH_CYC=2): vector table, cycle-numbered
// scenarios and a randomized run against an event-level reference model.
module tb_pipe_hold_ctrl;

  localparam int unsigned FLUSH_CYC = 2;
`ifdef PIPE_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        jump;
    logic [31:0] jaddr;
    logic        hex;
    logic        hbus;
    logic        irq;
    logic [31:0] iaddr;
  } in_t;

  typedef struct packed {
    logic        ack;
    logic        redir;
    logic [31:0] raddr;
    logic        pc_st;
    logic        if_st;
    logic        ie_st;
    logic        if_fl;
    logic        ie_fl;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic        int_ack_o;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        id_ex_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        redirect_o;
  logic [31:0] redirect_addr_o;

  int checks;
  int failures;

  pipe_hold_ctrl #(.FLUSH_CYC(FLUSH_CYC), .PC_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_req_i      (jump_req_i),
    .jump_addr_i     (jump_addr_i),
    .hold_ex_i       (hold_ex_i),
    .hold_bus_i      (hold_bus_i),
    .int_req_i       (int_req_i),
    .int_addr_i      (int_addr_i),
    .int_ack_o       (int_ack_o),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .id_ex_stall_o   (id_ex_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .redirect_o      (redirect_o),
    .redirect_addr_o (redirect_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mki(input logic j, input logic [31:0] ja, input logic hx,
                              input logic hb, input logic ir, input logic [31:0] ia);
    in_t r;
    r.jump = j; r.jaddr = ja; r.hex = hx; r.hbus = hb; r.irq = ir; r.iaddr = ia;
    return r;
  endfunction

  function automatic out_t mko(input logic ak, input logic rd, input logic [31:0] ra,
                               input logic ps, input logic is, input logic es,
                               input logic ifl, input logic efl);
    out_t r;
    r.ack = ak; r.redir = rd; r.raddr = ra; r.pc_st = ps;
    r.if_st = is; r.ie_st = es; r.if_fl = ifl; r.ie_fl = efl;
    return r;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("ack=%0b redir=%0b addr=%08h pc_st=%0b ifid_st=%0b idex_st=%0b ifid_fl=%0b idex_fl=%0b",
                     o.ack, o.redir, o.raddr, o.pc_st, o.if_st, o.ie_st, o.if_fl, o.ie_fl);
  endfunction

  task automatic drive(input in_t i);
    jump_req_i  = i.jump;
    jump_addr_i = i.jaddr;
    hold_ex_i   = i.hex;
    hold_bus_i  = i.hbus;
    int_req_i   = i.irq;
    int_addr_i  = i.iaddr;
  endtask

  task automatic check_now(input out_t e, input string nm);
    out_t g;
    g = mko(int_ack_o, redirect_o, redirect_addr_o, pc_stall_o,
            if_id_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got %s | exp %s", nm, fmt(g), fmt(e));
    end
  endtask

  // One clock cycle: inputs change just after the edge, outputs sampled mid-cycle
  task automatic cyc(input in_t i, input out_t e, input string nm);
    @(posedge clk);
    #1;
    drive(i);
    @(negedge clk);
    check_now(e, nm);
  endtask

  // ---------------- reference model (event level) ----------------
  bit          m_wait;
  logic [31:0] m_pend;
  int          m_bub;
  bit          m_draining;
  int          m_left;
  bit          m_entry;

  task automatic model_reset();
    m_wait = 1'b0; m_pend = '0; m_bub = 0;
    m_draining = 1'b0; m_left = 0; m_entry = 1'b0;
  endtask

  task automatic model_step(input in_t i, output out_t o);
    o = '0;
    if (m_wait) begin
      o.redir = 1'b1; o.raddr = m_pend; o.if_fl = 1'b1; o.ie_st = i.hex;
      if (!i.hbus) begin
        m_wait = 1'b0;
        m_bub  = FLUSH_CYC - 1;
      end
    end else if (m_entry) begin
      o.ack = 1'b1; o.redir = 1'b1; o.raddr = i.iaddr; o.if_fl = 1'b1; o.ie_fl = 1'b1;
      m_entry = 1'b0;
      if (i.hbus) begin
        m_wait = 1'b1;
        m_pend = i.iaddr;
      end else begin
        m_bub = FLUSH_CYC - 1;
      end
    end else if (m_draining && i.irq) begin
      o.pc_st = 1'b1; o.if_fl = 1'b1; o.ie_st = i.hex;
      if (i.jump) begin
        o.redir = 1'b1; o.raddr = i.jaddr; o.ie_fl = 1'b1;
        m_left = 2;
      end else if (!i.hex) begin
        m_left--;
        if (m_left == 0) begin
          m_draining = 1'b0;
          m_entry    = 1'b1;
        end
      end
    end else if (m_bub > 0 && !i.jump) begin
      o.if_fl = 1'b1; o.pc_st = i.hex | i.hbus; o.ie_st = i.hex;
      m_bub--;
    end else begin
      m_draining = 1'b0;
      m_bub      = 0;
      if (i.jump) begin
        o.redir = 1'b1; o.raddr = i.jaddr; o.if_fl = 1'b1; o.ie_fl = 1'b1;
        if (i.hbus) begin
          m_wait = 1'b1;
          m_pend = i.jaddr;
        end else begin
          m_bub = FLUSH_CYC - 1;
        end
      end else if (INT_EN && i.irq) begin
        o.pc_st = 1'b1; o.if_fl = 1'b1; o.ie_st = i.hex;
        m_draining = 1'b1;
        m_left     = 2;
      end else if (i.hex) begin
        o.pc_st = 1'b1; o.if_st = 1'b1; o.ie_st = 1'b1;
      end else if (i.hbus) begin
        o.pc_st = 1'b1; o.if_fl = 1'b1;
      end
    end
    if (o.redir) o.pc_st = 1'b0;
    if (o.if_fl) o.if_st = 1'b0;
    if (o.ie_fl) o.ie_st = 1'b0;
  endtask

  // Reset pulse with all requests asserted; outputs must stay low throughout
  task automatic do_reset(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(mki(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 32'h8000_0000));
    #1;
    check_now('0, nm);
    @(negedge clk);
    @(negedge clk);
    drive(mki(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    rst = 1'b1;
    model_reset();
  endtask

  vec_t tbl[$];

  initial begin
    out_t        e;
    in_t         vi;
    out_t        me;
    logic        r_irq;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(mki(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    model_reset();

    // ---------------- vector table (state carried row to row) ----------------
    tbl.push_back('{mki(0, 32'h0,   0, 0, 0, 0), mko(0, 0, 32'h0,   0, 0, 0, 0, 0)});
    tbl.push_back('{mki(1, 32'h100, 0, 0, 0, 0), mko(0, 1, 32'h100, 0, 0, 0, 1, 1)});
    tbl.push_back('{mki(0, 32'h0,   0, 0, 0, 0), mko(0, 0, 32'h0,   0, 0, 0, 1, 0)});
    tbl.push_back('{mki(0, 32'h0,   0, 0, 0, 0), mko(0, 0, 32'h0,   0, 0, 0, 0, 0)});
    tbl.push_back('{mki(0, 32'h0,   1, 0, 0, 0), mko(0, 0, 32'h0,   1, 1, 1, 0, 0)});
    tbl.push_back('{mki(0, 32'h0,   0, 1, 0, 0), mko(0, 0, 32'h0,   1, 0, 0, 1, 0)});
    tbl.push_back('{mki(0, 32'h0,   1, 1, 0, 0), mko(0, 0, 32'h0,   1, 1, 1, 0, 0)});
    tbl.push_back('{mki(1, 32'h200, 0, 1, 0, 0), mko(0, 1, 32'h200, 0, 0, 0, 1, 1)});
    tbl.push_back('{mki(0, 32'h300, 1, 1, 0, 0), mko(0, 1, 32'h200, 0, 0, 1, 1, 0)});
    tbl.push_back('{mki(0, 32'h0,   0, 0, 0, 0), mko(0, 1, 32'h200, 0, 0, 0, 1, 0)});
    tbl.push_back('{mki(0, 32'h0,   1, 0, 0, 0), mko(0, 0, 32'h0,   1, 0, 1, 1, 0)});
    tbl.push_back('{mki(1, 32'h400, 0, 0, 0, 0), mko(0, 1, 32'h400, 0, 0, 0, 1, 1)});
    tbl.push_back('{mki(1, 32'h500, 1, 0, 0, 0), mko(0, 1, 32'h500, 0, 0, 0, 1, 1)});
    tbl.push_back('{mki(0, 32'h0,   0, 1, 0, 0), mko(0, 0, 32'h0,   1, 0, 0, 1, 0)});
    tbl.push_back('{mki(0, 32'h0,   0, 0, 0, 0), mko(0, 0, 32'h0,   0, 0, 0, 0, 0)});
    tbl.push_back('{mki(1, 32'h600, 1, 0, 0, 0), mko(0, 1, 32'h600, 0, 0, 0, 1, 1)});
    tbl.push_back('{mki(0, 32'h0,   0, 0, 0, 0), mko(0, 0, 32'h0,   0, 0, 0, 1, 0)});

    do_reset("reset_initial");
    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].i, tbl[k].o, $sformatf("table_row%0d", k));
    end

    // ---------------- jump at cycle 10, two-cycle IF/ID flush ----------------
    do_reset("reset_jump10");
    for (int c = 0; c <= 12; c++) begin
      vi = mki(c == 10, 32'h0000_0100, 0, 0, 0, 0);
      if (c == 10)      e = mko(0, 1, 32'h100, 0, 0, 0, 1, 1);
      else if (c == 11) e = mko(0, 0, 32'h0, 0, 0, 0, 1, 0);
      else              e = '0;
      cyc(vi, e, $sformatf("jump10_c%0d", c));
    end

    // ---------------- hold_ex for cycles 5..9 ----------------
    do_reset("reset_holdex");
    for (int c = 0; c <= 11; c++) begin
      vi = mki(0, 0, (c >= 5 && c <= 9), 0, 0, 0);
      e  = (c >= 5 && c <= 9) ? mko(0, 0, 0, 1, 1, 1, 0, 0) : out_t'('0);
      cyc(vi, e, $sformatf("holdex_c%0d", c));
    end

    // ---------------- jump at 3 with bus busy 3..6, target changes later ----------------
    do_reset("reset_busjump");
    for (int c = 0; c <= 9; c++) begin
      vi = mki(c == 3, (c == 3) ? 32'h1234_5678 : (32'hDEAD_0000 + 32'(c)),
               0, (c >= 3 && c <= 6), 0, 0);
      if (c >= 3 && c <= 7) e = mko(0, 1, 32'h1234_5678, 0, 0, 0, 1, (c == 3));
      else if (c == 8)      e = mko(0, 0, 32'h0, 0, 0, 0, 1, 0);
      else                  e = '0;
      cyc(vi, e, $sformatf("busjump_c%0d", c));
    end

    // ---------------- async reset in the middle of a held redirect ----------------
    do_reset("reset_rw");
    cyc(mki(1, 32'hA0, 0, 1, 0, 0), mko(0, 1, 32'hA0, 0, 0, 0, 1, 1), "rw_enter");
    cyc(mki(0, 32'h0,  0, 1, 0, 0), mko(0, 1, 32'hA0, 0, 0, 0, 1, 0), "rw_hold");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_now('0, "rw_async_reset");
    @(negedge clk);
    rst = 1'b1;
    cyc(mki(0, 32'h0, 0, 1, 0, 0), mko(0, 0, 32'h0, 1, 0, 0, 1, 0), "rw_after_release");
    cyc(mki(0, 32'h0, 0, 0, 0, 0), '0, "rw_after_idle");

`ifdef PIPE_CTRL_INT_EN
    // ---------------- interrupt entry with EX busy 0..3 ----------------
    do_reset("reset_int");
    for (int c = 0; c <= 8; c++) begin
      vi = mki(0, 0, (c <= 3), 0, (c <= 6), 32'h8000_0004);
      if (c <= 5)       e = mko(0, 0, 32'h0, 1, 0, (c <= 3), 1, 0);
      else if (c == 6)  e = mko(1, 1, 32'h8000_0004, 0, 0, 0, 1, 1);
      else if (c == 7)  e = mko(0, 0, 32'h0, 0, 0, 0, 1, 0);
      else              e = '0;
      cyc(vi, e, $sformatf("int_c%0d", c));
    end

    // ---------------- same, jump at cycle 5 restarts the drain ----------------
    do_reset("reset_intjump");
    for (int c = 0; c <= 10; c++) begin
      vi = mki(c == 5, 32'h0000_0200, (c <= 3), 0, (c <= 8), 32'h8000_0004);
      if (c <= 4)       e = mko(0, 0, 32'h0, 1, 0, (c <= 3), 1, 0);
      else if (c == 5)  e = mko(0, 1, 32'h200, 0, 0, 0, 1, 1);
      else if (c <= 7)  e = mko(0, 0, 32'h0, 1, 0, 0, 1, 0);
      else if (c == 8)  e = mko(1, 1, 32'h8000_0004, 0, 0, 0, 1, 1);
      else if (c == 9)  e = mko(0, 0, 32'h0, 0, 0, 0, 1, 0);
      else              e = '0;
      cyc(vi, e, $sformatf("intjump_c%0d", c));
    end
`else
    // ---------------- interrupts disabled: request is ignored ----------------
    do_reset("reset_intoff");
    for (int c = 0; c < 20; c++) begin
      vi = mki(0, 0, 0, 0, 1, $urandom);
      cyc(vi, '0, $sformatf("intoff_c%0d", c));
    end
`endif

    // ---------------- randomized run against the reference model ----------------
    do_reset("reset_random");
    r_irq = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) r_irq = ~r_irq;
      vi = mki(($urandom_range(0, 5) == 0), $urandom,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               r_irq, $urandom);
      model_step(vi, me);
      cyc(vi, me, $sformatf("random_n%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Central stall/flush scheduler for the 3-stage RV32 pipeline (PC → IF/ID → ID/EX → EX). It arbitrates redirect, multi-cycle-execute, fetch-bus-wait and interrupt-entry requests into per-register stall (keep) and flush (load NOP) controls. It also drives the single PC redirect port. It sits beside the core top and owns every hold/flush input of the pipeline registers.

## Interface
- FLUSH_CYC, 1, cycles IF/ID is flushed after a redirect (≥1)
- PC_W, 32, address width
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- jump_req_i  in  1  EX-stage branch/jump taken
- jump_addr_i  in  PC_W  target of jump_req_i
- hold_ex_i  in  1  EX multi-cycle op busy (div/mul)
- hold_bus_i  in  1  fetch bus not ready
- int_req_i  in  1  level interrupt request from CLINT
- int_addr_i  in  PC_W  trap vector
- int_ack_o  out  1  one-cycle interrupt-entry acknowledge
- pc_stall_o, if_id_stall_o, id_ex_stall_o  out  1 each  register keeps value
- if_id_flush_o, id_ex_flush_o  out  1 each  register loads NOP
- redirect_o  out  1  PC loads redirect_addr_o
- redirect_addr_o  out  PC_W  redirect target

## Operation
- States: IDLE, BUBBLE, REDIR_WAIT, DRAIN, INT_ENTRY. Registers: state, bubble count, pending address, drain count.
- Outputs are combinational from state and inputs. While rst=0, every output is 0.
- Request priority in IDLE: jump_req_i > int_req_i > hold_ex_i > hold_bus_i.
- jump_req_i, hold_bus_i=0:
  - Same cycle: redirect_o=1, redirect_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1.
  - If FLUSH_CYC>1: bubble count ← FLUSH_CYC-1, go to BUBBLE. Otherwise stay in IDLE.
- jump_req_i, hold_bus_i=1:
  - Latch jump_addr_i and go to REDIR_WAIT.
  - REDIR_WAIT holds pc_stall_o=0, redirect_o=1 with the latched address, and if_id_flush_o=1 every cycle.
  - Leave REDIR_WAIT on the first cycle hold_bus_i=0. That cycle is the accepting redirect; then follow the BUBBLE rule.
- BUBBLE: if_id_flush_o=1 each cycle. Decrement the count; return to IDLE at 0. A jump_req_i arriving in BUBBLE is handled as in IDLE and reloads the count.
- hold_ex_i (no jump): pc_stall_o=if_id_stall_o=id_ex_stall_o=1.
- hold_bus_i only: pc_stall_o=1, if_id_flush_o=1. ID/EX and EX advance.
- int_req_i (no jump):
  - Go to DRAIN with drain count ← 2. DRAIN drives pc_stall_o=1 and if_id_flush_o=1.
  - The count decrements only when hold_ex_i=0. Go to INT_ENTRY when it reaches 0.
  - jump_req_i during DRAIN: redirect as in IDLE, stay in DRAIN, reload drain count to 2. redirect_o=1 overrides pc_stall_o for that cycle.
- INT_ENTRY (1 cycle): int_ack_o=1, redirect_o=1, redirect_addr_o=int_addr_i, if_id_flush_o=id_ex_flush_o=1. Then BUBBLE if FLUSH_CYC>1, else IDLE.
  - If hold_bus_i=1 in INT_ENTRY: latch int_addr_i, assert int_ack_o this cycle, go to REDIR_WAIT.
- int_req_i dropping during DRAIN: return to IDLE with no ack.
- Stall and flush on the same register: flush wins; the stall is suppressed.

## Timing
- Redirect latency 0 cycles (same cycle as jump_req_i) unless the bus is busy.
- First fetch from the target is in the cycle after the accepting redirect.
- Interrupt entry latency is 3 + (cycles with hold_ex_i=1) + (jump-induced restarts).
- Reset assertion is asynchronous. It returns the FSM to IDLE and discards any pending redirect or interrupt.
- Deassertion is sampled on clk; the first active cycle is IDLE.

## Configuration
- PIPE_CTRL_INT_EN defined: DRAIN and INT_ENTRY exist, and interrupt handling is as above.
- PIPE_CTRL_INT_EN undefined: int_req_i and int_addr_i are ignored, int_ack_o is tied 0, and DRAIN/INT_ENTRY are not generated.

## Structure
- Shared defines file holds the state encodings and the NOP-flush convention constant.
- One sub-module, pipe_bubble_cnt: a loadable down-counter with zero flag. It is instantiated twice, for the bubble and drain counts.

## Test plan
- FLUSH_CYC=2, jump_req_i=1 at cycle 10 with target 0x0000_0100:
  - Cycle 10: redirect_o=1, addr 0x100, both flushes=1.
  - Cycle 11: if_id_flush_o=1 only.
  - Cycle 12: all 0.
- hold_ex_i high for cycles 5–9: pc_stall_o, if_id_stall_o and id_ex_stall_o are 1 exactly in cycles 5–9; no flushes.
- jump_req_i at cycle 3 with hold_bus_i high for cycles 3–6:
  - redirect_o=1 with the latched address in cycles 3–7, even if jump_addr_i changes after cycle 3.
  - Cycle 7 accepts the redirect.
- int_req_i at cycle 0 with hold_ex_i high for cycles 0–3, int_addr 0x8000_0004: int_ack_o and redirect to 0x8000_0004 in cycle 6.
  - Repeat with jump_req_i at cycle 5: ack moves to cycle 8.
- rst driven low mid-REDIR_WAIT: all outputs 0 immediately. After release, redirect_o=0 until a new request.
- PIPE_CTRL_INT_EN undefined, int_req_i held 1: int_ack_o never asserts and the pipeline stays unstalled.
